cdb_arbiter: RTL and testbench

- Sits between the functional units (ALU, memory unit, future extra FUs) and the common data bus, replacing the fixed one-port-per-unit CDB wiring.
- Buffers each unit's completed result in a small per-source FIFO.
- Arbitrates round-robin onto two registered CDB broadcast ports, which feed the ROB, RS and load/store buffer.
- Back-pressures units through per-source ready; discards everything on ROB flush.

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs drained round-robin onto
// two registered CDB broadcast ports, with back-pressure and ROB flush.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ROB_FLUSH_Flag,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [5*NUM_SRC-1:0]   src_ROBEN,
    input  logic [32*NUM_SRC-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_exception,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [4:0]             out_ROBEN1,
    output logic [31:0]            out_Write_Data1,
    output logic                   out_EXCEPTION1,
    output logic [4:0]             out_ROBEN2,
    output logic [31:0]            out_Write_Data2,
    output logic                   out_EXCEPTION2,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_SRC - 1);

    typedef struct packed {
        logic [4:0]  roben;
        logic [31:0] data;
        logic        exc;
    } entry_t;

    entry_t           mem    [NUM_SRC][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_SRC];
    logic [PTR_W-1:0] wr_ptr [NUM_SRC];
    logic [CNT_W-1:0] count  [NUM_SRC];
    logic [IDX_W-1:0] rr_ptr;

    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_a_valid;
    logic               grant_b_valid;
    logic [IDX_W-1:0]   grant_a;
    logic [IDX_W-1:0]   grant_b;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   rr_next;
    entry_t             head_a;
    entry_t             head_b;

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // opens a slot and there is no path from the arbiter back to the sources.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            nonempty[i]  = (count[i] != '0);
            src_ready[i] = (count[i] < DEPTH_C) && !rst && !ROB_FLUSH_Flag;
            push[i]      = src_valid[i] && src_ready[i] && (src_ROBEN[5*i +: 5] != 5'd0);
        end
        busy = (|nonempty) && !rst;
    end

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        grant_a_valid = 1'b0;
        grant_b_valid = 1'b0;
        grant_a       = '0;
        grant_b       = '0;
        idx           = 0;
        cand          = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            cand = IDX_W'(idx);
            if (nonempty[cand]) begin
                if (!grant_a_valid) begin
                    grant_a_valid = 1'b1;
                    grant_a       = cand;
                end else if (!grant_b_valid) begin
                    grant_b_valid = 1'b1;
                    grant_b       = cand;
                end
            end
        end

        pop = '0;
        if (grant_a_valid) pop[grant_a] = 1'b1;
        if (grant_b_valid) pop[grant_b] = 1'b1;

        last_grant = grant_b_valid ? grant_b : grant_a;
        rr_next    = (last_grant == LAST_SRC) ? '0 : last_grant + IDX_W'(1);

        head_a = grant_a_valid ? mem[grant_a][rd_ptr[grant_a]] : '0;
        head_b = grant_b_valid ? mem[grant_b][rd_ptr[grant_b]] : '0;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || ROB_FLUSH_Flag) begin
            rr_ptr          <= '0;
            out_ROBEN1      <= '0;
            out_Write_Data1 <= '0;
            out_EXCEPTION1  <= 1'b0;
            out_ROBEN2      <= '0;
            out_Write_Data2 <= '0;
            out_EXCEPTION2  <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (grant_a_valid) rr_ptr <= rr_next;
            out_ROBEN1      <= head_a.roben;
            out_Write_Data1 <= head_a.data;
            out_EXCEPTION1  <= head_a.exc;
            out_ROBEN2      <= head_b.roben;
            out_Write_Data2 <= head_b.data;
            out_EXCEPTION2  <= head_b.exc;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                unique case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; count alone decides which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= '{roben: src_ROBEN[5*i +: 5],
                                       data:  src_data[32*i +: 32],
                                       exc:   src_exception[i]};
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DEPTH   = 2;

    typedef struct packed {
        logic [4:0]  roben;
        logic [31:0] data;
        logic        exc;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [NUM_SRC-1:0]    src_valid;
    logic [5*NUM_SRC-1:0]  src_ROBEN;
    logic [32*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]    src_exception;
    logic [NUM_SRC-1:0]    src_ready;
    logic [4:0]            out_ROBEN1;
    logic [31:0]           out_Write_Data1;
    logic                  out_EXCEPTION1;
    logic [4:0]            out_ROBEN2;
    logic [31:0]           out_Write_Data2;
    logic                  out_EXCEPTION2;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    entry_t     model_q [NUM_SRC][$];
    int         model_rr = 0;
    entry_t     exp1;
    entry_t     exp2;
    logic [4:0] bcast [$];

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .ROB_FLUSH_Flag  (flush),
        .src_valid       (src_valid),
        .src_ROBEN       (src_ROBEN),
        .src_data        (src_data),
        .src_exception   (src_exception),
        .src_ready       (src_ready),
        .out_ROBEN1      (out_ROBEN1),
        .out_Write_Data1 (out_Write_Data1),
        .out_EXCEPTION1  (out_EXCEPTION1),
        .out_ROBEN2      (out_ROBEN2),
        .out_Write_Data2 (out_Write_Data2),
        .out_EXCEPTION2  (out_EXCEPTION2),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input int i, input logic v, input logic [4:0] r,
                         input logic [31:0] d, input logic e);
        src_valid[i]          = v;
        src_ROBEN[5*i +: 5]   = r;
        src_data[32*i +: 32]  = d;
        src_exception[i]      = e;
    endtask

    task automatic clear_inputs();
        src_valid     = '0;
        src_ROBEN     = '0;
        src_data      = '0;
        src_exception = '0;
    endtask

    // One clock cycle: compare combinational outputs against the model before
    // the edge, advance the model by the arbitration rules, compare registers.
    task automatic tick();
        logic             exp_ready;
        logic             exp_busy;
        bit               acc [NUM_SRC];
        int               ga;
        int               gb;
        int               idx;
        #1;
        exp_busy = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            exp_ready = !rst && !flush && (model_q[i].size() < DEPTH);
            acc[i] = src_valid[i] && exp_ready && (src_ROBEN[5*i +: 5] != 5'd0);
            if (model_q[i].size() != 0) exp_busy = 1'b1;
            checks++;
            if (src_ready[i] !== exp_ready) begin
                failures++;
                $display("FAIL src_ready[%0d] got=%b exp=%b t=%0t", i, src_ready[i], exp_ready, $time);
            end
        end
        if (rst) exp_busy = 1'b0;
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL busy got=%b exp=%b t=%0t", busy, exp_busy, $time);
        end

        exp1 = '0;
        exp2 = '0;
        if (rst || flush) begin
            for (int i = 0; i < NUM_SRC; i++) model_q[i].delete();
            model_rr = 0;
        end else begin
            ga = -1;
            gb = -1;
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = (model_rr + k) % NUM_SRC;
                if (model_q[idx].size() > 0) begin
                    if (ga < 0) ga = idx;
                    else if (gb < 0) gb = idx;
                end
            end
            if (ga >= 0) exp1 = model_q[ga].pop_front();
            if (gb >= 0) exp2 = model_q[gb].pop_front();
            if (gb >= 0) model_rr = (gb + 1) % NUM_SRC;
            else if (ga >= 0) model_rr = (ga + 1) % NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++)
                if (acc[i])
                    model_q[i].push_back('{roben: src_ROBEN[5*i +: 5],
                                           data:  src_data[32*i +: 32],
                                           exc:   src_exception[i]});
        end

        @(posedge clk);
        #1;
        checks++;
        if ({out_ROBEN1, out_Write_Data1, out_EXCEPTION1} !== exp1) begin
            failures++;
            $display("FAIL port1 got=%0d/%h/%b exp=%0d/%h/%b t=%0t", out_ROBEN1, out_Write_Data1,
                     out_EXCEPTION1, exp1.roben, exp1.data, exp1.exc, $time);
        end
        checks++;
        if ({out_ROBEN2, out_Write_Data2, out_EXCEPTION2} !== exp2) begin
            failures++;
            $display("FAIL port2 got=%0d/%h/%b exp=%0d/%h/%b t=%0t", out_ROBEN2, out_Write_Data2,
                     out_EXCEPTION2, exp2.roben, exp2.data, exp2.exc, $time);
        end
        if (out_ROBEN1 != 5'd0) bcast.push_back(out_ROBEN1);
        if (out_ROBEN2 != 5'd0) bcast.push_back(out_ROBEN2);
    endtask

    task automatic apply_reset();
        clear_inputs();
        flush = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_ROBEN1 !== 5'd0 || out_ROBEN2 !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", out_ROBEN1, out_ROBEN2, busy);
        end
    endtask

    task automatic test_single();
        drive(1, 1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || out_ROBEN1 !== 5'd0) begin
            failures++;
            $display("FAIL single_accept got busy=%b roben1=%0d exp busy=1 roben1=0", busy, out_ROBEN1);
        end
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd5 || out_Write_Data1 !== 32'h1234 || out_ROBEN2 !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_bcast got=%0d/%h/%0d/%b exp=5/00001234/0/0", out_ROBEN1,
                     out_Write_Data1, out_ROBEN2, busy);
        end
    endtask

    task automatic test_two_sources();
        apply_reset();
        drive(0, 1'b1, 5'd3, 32'hA0, 1'b0);
        drive(2, 1'b1, 5'd7, 32'hA2, 1'b1);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd3 || out_ROBEN2 !== 5'd7 || out_EXCEPTION2 !== 1'b1) begin
            failures++;
            $display("FAIL two_src got=%0d/%0d/%b exp=3/7/1", out_ROBEN1, out_ROBEN2, out_EXCEPTION2);
        end
        // Pointer is now 3, so source 3 outranks source 0.
        drive(0, 1'b1, 5'd9, 32'hB0, 1'b0);
        drive(3, 1'b1, 5'd10, 32'hB3, 1'b0);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd10 || out_ROBEN2 !== 5'd9) begin
            failures++;
            $display("FAIL rr_after_two got=%0d/%0d exp=10/9", out_ROBEN1, out_ROBEN2);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, 5'(i + 1), 32'(100 + i), 1'b0);
        tick();
        clear_inputs();
        drive(0, 1'b1, 5'd5, 32'h55, 1'b0);
        tick();
        clear_inputs();
        checks++;
        if (out_ROBEN1 !== 5'd1 || out_ROBEN2 !== 5'd2) begin
            failures++;
            $display("FAIL contend_c1 got=%0d/%0d exp=1/2", out_ROBEN1, out_ROBEN2);
        end
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd3 || out_ROBEN2 !== 5'd4) begin
            failures++;
            $display("FAIL contend_c2 got=%0d/%0d exp=3/4", out_ROBEN1, out_ROBEN2);
        end
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd5 || out_ROBEN2 !== 5'd0) begin
            failures++;
            $display("FAIL contend_c3 got=%0d/%0d exp=5/0", out_ROBEN1, out_ROBEN2);
        end
    endtask

    task automatic test_backpressure();
        bit         done;
        int         seen;
        logic [4:0] want;
        apply_reset();
        bcast.delete();
        drive(0, 1'b1, 5'd30, 32'h30, 1'b0);
        tick();
        clear_inputs();
        tick();
        drive(0, 1'b1, 5'd20, 32'h20, 1'b0);
        drive(1, 1'b1, 5'd1, 32'h1, 1'b0);
        drive(2, 1'b1, 5'd2, 32'h2, 1'b0);
        drive(3, 1'b1, 5'd3, 32'h3, 1'b0);
        tick();
        drive(0, 1'b1, 5'd21, 32'h21, 1'b1);
        drive(1, 1'b1, 5'd4, 32'h4, 1'b0);
        drive(2, 1'b1, 5'd5, 32'h5, 1'b0);
        drive(3, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        checks++;
        if (src_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_full got=%b exp=0", src_ready[0]);
        end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive(0, 1'b1, 5'd22, 32'h22, 1'b0);
            for (int i = 1; i < NUM_SRC; i++)
                drive(i, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 15)), $urandom, 1'b0);
            if (src_ready[0]) done = 1'b1;
            tick();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL bp_third_accept got=0 exp=1");
        end
        clear_inputs();
        for (int c = 0; c < 40 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got busy=%b exp=0", busy);
        end
        seen = 0;
        want = 5'd20;
        foreach (bcast[j]) begin
            if (bcast[j] >= 5'd20 && bcast[j] <= 5'd22) begin
                checks++;
                if (bcast[j] !== want) begin
                    failures++;
                    $display("FAIL bp_order got=%0d exp=%0d", bcast[j], want);
                end
                want = want + 5'd1;
                seen++;
            end
        end
        checks++;
        if (seen != 3) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=3", seen);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(2, 1'b1, 5'd8, 32'h8, 1'b0);
        tick();
        clear_inputs();
        tick();
        drive(1, 1'b1, 5'd11, 32'h11, 1'b0);
        tick();
        drive(1, 1'b1, 5'd12, 32'h12, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (src_ready !== '0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0000", src_ready);
        end
        tick();
        flush = 1'b0;
        clear_inputs();
        checks++;
        if (busy !== 1'b0 || out_ROBEN1 !== 5'd0) begin
            failures++;
            $display("FAIL flush_state got busy=%b roben1=%0d exp 0/0", busy, out_ROBEN1);
        end
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd0 || out_ROBEN2 !== 5'd0) begin
            failures++;
            $display("FAIL flush_leak got=%0d/%0d exp=0/0", out_ROBEN1, out_ROBEN2);
        end
        drive(0, 1'b1, 5'd13, 32'h13, 1'b0);
        drive(3, 1'b1, 5'd14, 32'h14, 1'b0);
        tick();
        clear_inputs();
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd13 || out_ROBEN2 !== 5'd14) begin
            failures++;
            $display("FAIL flush_rr got=%0d/%0d exp=13/14", out_ROBEN1, out_ROBEN2);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < NUM_SRC; i++) drive(i, 1'b1, 5'(16 + i), 32'(i), 1'b0);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (src_ready !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_comb got ready=%b busy=%b exp 0000/0", src_ready, busy);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        checks++;
        if (out_ROBEN1 !== 5'd0 || out_ROBEN2 !== 5'd0) begin
            failures++;
            $display("FAIL midreset_out got=%0d/%0d exp=0/0", out_ROBEN1, out_ROBEN2);
        end
        drive(2, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_roben_busy got=%b exp=0", busy);
        end
        tick();
        checks++;
        if (out_ROBEN1 !== 5'd0 || out_Write_Data1 !== 32'd0) begin
            failures++;
            $display("FAIL zero_roben_bcast got=%0d/%h exp=0/0", out_ROBEN1, out_Write_Data1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                drive(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        clear_inputs();
        for (int c = 0; c < 10; c++) tick();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_two_sources();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
